// File: rtl/jt51_pkg.sv
// Shared definitions for the JT51 CPU write controller: register addresses,
// address-group codes and the packed register-file update strobe bundle.
package jt51_pkg;

  localparam int BUSY_CYC_DEF = 32;

  // Global register addresses
  localparam logic [7:0] REG_TEST   = 8'h01;
  localparam logic [7:0] REG_KEYON  = 8'h08;
  localparam logic [7:0] REG_NOISE  = 8'h0F;
  localparam logic [7:0] REG_CLKA1  = 8'h10;
  localparam logic [7:0] REG_CLKA2  = 8'h11;
  localparam logic [7:0] REG_CLKB   = 8'h12;
  localparam logic [7:0] REG_TIMER  = 8'h14;
  localparam logic [7:0] REG_LFRQ   = 8'h18;
  localparam logic [7:0] REG_PMDAMD = 8'h19;
  localparam logic [7:0] REG_CTW    = 8'h1B;

  // addr[7:5] selects the register group for 0x20-0xFF
  localparam logic [2:0] GRP_CH    = 3'd1;
  localparam logic [2:0] GRP_DT1   = 3'd2;
  localparam logic [2:0] GRP_TL    = 3'd3;
  localparam logic [2:0] GRP_KS    = 3'd4;
  localparam logic [2:0] GRP_AMSEN = 3'd5;
  localparam logic [2:0] GRP_DT2   = 3'd6;
  localparam logic [2:0] GRP_D1L   = 3'd7;

  // addr[4:3] selects the channel-wide register inside GRP_CH
  localparam logic [1:0] SUB_RL  = 2'd0;
  localparam logic [1:0] SUB_KC  = 2'd1;
  localparam logic [1:0] SUB_KF  = 2'd2;
  localparam logic [1:0] SUB_PMS = 2'd3;

  typedef struct packed {
    logic rl;
    logic kc;
    logic kf;
    logic pms;
    logic dt1;
    logic tl;
    logic ks;
    logic amsen;
    logic dt2;
    logic d1l;
    logic keyon;
  } upd_t;

endpackage

// File: rtl/jt51_wrctl_dec.sv
// Combinational address decode: selected register address to a single update
// strobe plus the operator/channel it targets.
module jt51_wrctl_dec
  import jt51_pkg::*;
(
  input  logic [7:0] addr,
  output upd_t       up,
  output logic [1:0] op,
  output logic [2:0] ch
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    up = '0;
    op = '0;
    ch = '0;
    if (addr == REG_KEYON) up.keyon = 1'b1;
    if (addr[7:5] != 3'd0) begin
      ch = addr[2:0];
      if (addr[7:5] == GRP_CH) begin
        // Channel-wide registers have no operator; addr[4:3] picks the register
        case (addr[4:3])
          SUB_RL:  up.rl  = 1'b1;
          SUB_KC:  up.kc  = 1'b1;
          SUB_KF:  up.kf  = 1'b1;
          SUB_PMS: up.pms = 1'b1;
          default: ;
        endcase
      end else begin
        op = addr[4:3];
        case (addr[7:5])
          GRP_DT1:   up.dt1   = 1'b1;
          GRP_TL:    up.tl    = 1'b1;
          GRP_KS:    up.ks    = 1'b1;
          GRP_AMSEN: up.amsen = 1'b1;
          GRP_DT2:   up.dt2   = 1'b1;
          GRP_D1L:   up.d1l   = 1'b1;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/jt51_wrctl.sv
// JT51 CPU write controller: edge-detects CPU writes, holds each data write
// toward the register file for one slot rotation and updates global registers.
module jt51_wrctl
  import jt51_pkg::*;
#(
  parameter int BUSY_CYC = BUSY_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       busy,
  output logic [7:0] dout,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       en_irq_A,
  output logic       en_irq_B,
  output logic       csm,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       lfo_rst,
  output logic [7:0] lfo_freq,
  output logic [1:0] lfo_w,
  output logic [6:0] amd,
  output logic [6:0] pmd,
  output logic [1:0] ct,
  output logic [4:0] nfrq,
  output logic       ne
);

  localparam int CW = $clog2(BUSY_CYC + 1);

  logic          wr_req, wr_prev, wr_edge;
  logic          accept_addr, accept_data;
  logic [1:0]    rdy_sr;
  logic [7:0]    sel_addr;
  logic [CW-1:0] cnt;
  upd_t          dec_up, up_q;
  logic [1:0]    dec_op;
  logic [2:0]    dec_ch;

  assign wr_req      = !cs_n && !wr_n;
  assign wr_edge     = wr_req && !wr_prev && rdy_sr[1];
  assign accept_addr = wr_edge && !a0;
  assign accept_data = wr_edge && a0 && !busy;

  jt51_wrctl_dec u_dec (
    .addr (sel_addr),
    .up   (dec_up),
    .op   (dec_op),
    .ch   (dec_ch)
  );

  // rdy_sr fills with ones over two clocks after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      rdy_sr   <= '0;
      wr_prev  <= 1'b0;
      sel_addr <= '0;
    end else begin
      rdy_sr  <= {rdy_sr[0], 1'b1};
      wr_prev <= wr_req;
      if (accept_addr) sel_addr <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      up_q <= '0;
      dout <= '0;
      op   <= '0;
      ch   <= '0;
    end else if (accept_data) begin
      busy <= 1'b1;
      cnt  <= CW'(BUSY_CYC);
      up_q <= dec_up;
      dout <= din;
      op   <= dec_op;
      ch   <= dec_ch;
    end else if (busy && cen) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        up_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_A    <= '0;
      value_B    <= '0;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      en_irq_A   <= 1'b0;
      en_irq_B   <= 1'b0;
      csm        <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      lfo_rst    <= 1'b0;
      lfo_freq   <= '0;
      lfo_w      <= '0;
      amd        <= '0;
      pmd        <= '0;
      ct         <= '0;
      nfrq       <= '0;
      ne         <= 1'b0;
    end else begin
      // Flag clears last until the next cen; a new 0x14 write below overrides
      if (cen) begin
        clr_flag_A <= 1'b0;
        clr_flag_B <= 1'b0;
      end
      if (accept_data) begin
        case (sel_addr)
          REG_TEST:  lfo_rst <= din[1];
          REG_NOISE: begin
            ne   <= din[7];
            nfrq <= din[4:0];
          end
          REG_CLKA1: value_A[9:2] <= din;
          REG_CLKA2: value_A[1:0] <= din[1:0];
          REG_CLKB:  value_B <= din;
          REG_TIMER: begin
            load_A     <= din[0];
            load_B     <= din[1];
            en_irq_A   <= din[2];
            en_irq_B   <= din[3];
            clr_flag_A <= din[4];
            clr_flag_B <= din[5];
            csm        <= din[7];
          end
          REG_LFRQ:  lfo_freq <= din;
          REG_PMDAMD: begin
            if (din[7]) pmd <= din[6:0];
            else        amd <= din[6:0];
          end
          REG_CTW: begin
            ct    <= din[7:6];
            lfo_w <= din[1:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign up_rl    = up_q.rl;
  assign up_kc    = up_q.kc;
  assign up_kf    = up_q.kf;
  assign up_pms   = up_q.pms;
  assign up_dt1   = up_q.dt1;
  assign up_tl    = up_q.tl;
  assign up_ks    = up_q.ks;
  assign up_amsen = up_q.amsen;
  assign up_dt2   = up_q.dt2;
  assign up_d1l   = up_q.d1l;
  assign up_keyon = up_q.keyon;

endmodule

// File: tb/tb_jt51_wrctl.sv
// Directed self-checking bench for jt51_wrctl: strobe decode, busy window,
// dropped writes, global registers, cen freeze and asynchronous reset.
module tb_jt51_wrctl;

  logic       clk = 1'b0;
  logic       rst_n, cen, cs_n, wr_n, a0;
  logic [7:0] din;
  logic       busy;
  logic [7:0] dout;
  logic [1:0] op;
  logic [2:0] ch;
  logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen;
  logic       up_dt2, up_d1l, up_keyon;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, en_irq_A, en_irq_B, csm, clr_flag_A, clr_flag_B;
  logic       lfo_rst;
  logic [7:0] lfo_freq;
  logic [1:0] lfo_w, ct;
  logic [6:0] amd, pmd;
  logic [4:0] nfrq;
  logic       ne;

  int  checks = 0;
  int  errors = 0;
  int  ticks  = 0;
  int  acc    = 0;
  bit  cen_run = 1'b1;

  // Strobe bit positions inside ups
  localparam int S_RL = 10, S_KC = 9, S_KF = 8, S_DT1 = 6, S_TL = 5, S_KEYON = 0;

  logic [10:0] ups;
  assign ups = {up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen,
                up_dt2, up_d1l, up_keyon};

  jt51_wrctl dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0),
    .din(din), .busy(busy), .dout(dout), .op(op), .ch(ch),
    .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms),
    .up_dt1(up_dt1), .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen),
    .up_dt2(up_dt2), .up_d1l(up_d1l), .up_keyon(up_keyon),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .en_irq_A(en_irq_A), .en_irq_B(en_irq_B), .csm(csm),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .lfo_rst(lfo_rst), .lfo_freq(lfo_freq), .lfo_w(lfo_w), .amd(amd),
    .pmd(pmd), .ct(ct), .nfrq(nfrq), .ne(ne)
  );

  always #5 clk = ~clk;

  // cen pulses every other clk while running; changes away from posedge
  initial cen = 1'b0;
  always @(negedge clk) cen = cen_run ? ~cen : 1'b0;

  always @(posedge clk) if (cen && rst_n) ticks++;

  task automatic cpu_wr(input logic addr_sel, input logic [7:0] data);
    @(posedge clk);
    @(negedge clk);
    a0 = addr_sel; din = data; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1;
    cs_n = 1'b1; wr_n = 1'b1;
    acc = ticks;
  endtask

  task automatic reg_wr(input logic [7:0] addr, input logic [7:0] data);
    cpu_wr(1'b0, addr);
    cpu_wr(1'b1, data);
  endtask

  task automatic wait_ticks(input int target);
    int guard = 0;
    while (ticks < target && guard < 1000) begin
      @(posedge clk); #1; guard++;
    end
    if (ticks < target) begin
      checks++; errors++;
      $display("FAIL wait_ticks: got %0d cen ticks required %0d", ticks, target);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 300) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wait_idle: busy got %b required 0", busy);
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (ups !== 11'd0) begin errors++; $display("FAIL rst_ups: got %h required 000", ups); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h required 00", dout); end
    checks++; if (value_A !== 10'd0) begin errors++; $display("FAIL rst_value_A: got %h required 000", value_A); end
  endtask

  task automatic test_kc();
    reg_wr(8'h28, 8'h4A);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kc_busy: got %b required 1", busy); end
    checks++; if (ups !== 11'd1 << S_KC) begin errors++; $display("FAIL kc_ups: got %h required %h", ups, 11'd1 << S_KC); end
    checks++; if ({op, ch} !== 5'd0) begin errors++; $display("FAIL kc_opch: got %h required 00", {op, ch}); end
    checks++; if (dout !== 8'h4A) begin errors++; $display("FAIL kc_dout: got %h required 4a", dout); end
    wait_ticks(acc + 31);
    checks++; if ({busy, up_kc, dout} !== {2'b11, 8'h4A}) begin errors++; $display("FAIL kc_tick31: got %h required 34a", {busy, up_kc, dout}); end
    wait_ticks(acc + 32);
    checks++; if ({busy, ups} !== 12'd0) begin errors++; $display("FAIL kc_tick32: got %h required 000", {busy, ups}); end
  endtask

  task automatic test_tl();
    reg_wr(8'h7D, 8'h15);
    checks++; if (ups !== 11'd1 << S_TL) begin errors++; $display("FAIL tl_ups: got %h required %h", ups, 11'd1 << S_TL); end
    checks++; if (op !== 2'd3) begin errors++; $display("FAIL tl_op: got %0d required 3", op); end
    checks++; if (ch !== 3'd5) begin errors++; $display("FAIL tl_ch: got %0d required 5", ch); end
    checks++; if (dout !== 8'h15) begin errors++; $display("FAIL tl_dout: got %h required 15", dout); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int first;
    reg_wr(8'h40, 8'h11);
    first = acc;
    reg_wr(8'h60, 8'h22);
    checks++; if ({busy, dout} !== {1'b1, 8'h11}) begin errors++; $display("FAIL b2b_dout: got %h required 111", {busy, dout}); end
    checks++; if (ups !== 11'd1 << S_DT1) begin errors++; $display("FAIL b2b_ups: got %h required %h", ups, 11'd1 << S_DT1); end
    wait_ticks(first + 32);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end: busy got %b required 0", busy); end
    cpu_wr(1'b1, 8'h33);
    checks++; if ({ups, dout} !== {11'd1 << S_TL, 8'h33}) begin errors++; $display("FAIL b2b_new: got %h required %h", {ups, dout}, {11'd1 << S_TL, 8'h33}); end
    wait_idle();
  endtask

  task automatic test_keyon();
    reg_wr(8'h08, 8'h78);
    checks++; if ({busy, ups, dout} !== {1'b1, 11'd1 << S_KEYON, 8'h78}) begin errors++; $display("FAIL keyon: got %h required %h", {busy, ups, dout}, {1'b1, 11'd1 << S_KEYON, 8'h78}); end
    wait_idle();
  endtask

  task automatic test_timers();
    logic [7:0] ga [7] = '{8'h12, 8'h0F, 8'h18, 8'h19, 8'h19, 8'h1B, 8'h01};
    logic [7:0] gd [7] = '{8'hA5, 8'h9A, 8'h77, 8'h85, 8'h33, 8'hC2, 8'h02};
    reg_wr(8'h10, 8'hFF);
    checks++; if ({busy, ups} !== {1'b1, 11'd0}) begin errors++; $display("FAIL glob_busy: got %h required 800", {busy, ups}); end
    wait_idle();
    reg_wr(8'h11, 8'h02);
    checks++; if (value_A !== 10'h3FE) begin errors++; $display("FAIL value_A: got %h required 3fe", value_A); end
    wait_idle();
    reg_wr(8'h14, 8'h30);
    checks++; if ({clr_flag_A, clr_flag_B} !== 2'b11) begin errors++; $display("FAIL clr_set: got %b required 11", {clr_flag_A, clr_flag_B}); end
    wait_ticks(acc + 1);
    checks++; if ({clr_flag_A, clr_flag_B} !== 2'b00) begin errors++; $display("FAIL clr_drop: got %b required 00", {clr_flag_A, clr_flag_B}); end
    wait_idle();
    reg_wr(8'h14, 8'h8F);
    checks++; if ({csm, en_irq_B, en_irq_A, load_B, load_A, clr_flag_A} !== 6'b111110) begin errors++; $display("FAIL timer_ctl: got %b required 111110", {csm, en_irq_B, en_irq_A, load_B, load_A, clr_flag_A}); end
    wait_idle();
    for (int i = 0; i < 7; i++) begin
      reg_wr(ga[i], gd[i]);
      wait_idle();
    end
    checks++; if (value_B !== 8'hA5) begin errors++; $display("FAIL value_B: got %h required a5", value_B); end
    checks++; if ({ne, nfrq} !== 6'h3A) begin errors++; $display("FAIL noise: got %h required 3a", {ne, nfrq}); end
    checks++; if (lfo_freq !== 8'h77) begin errors++; $display("FAIL lfo_freq: got %h required 77", lfo_freq); end
    checks++; if ({pmd, amd} !== {7'h05, 7'h33}) begin errors++; $display("FAIL pmd_amd: got %h required %h", {pmd, amd}, {7'h05, 7'h33}); end
    checks++; if ({ct, lfo_w, lfo_rst} !== 5'b11101) begin errors++; $display("FAIL ct_w_rst: got %b required 11101", {ct, lfo_w, lfo_rst}); end
  endtask

  task automatic test_cen_freeze();
    reg_wr(8'h30, 8'h5C);
    wait_ticks(acc + 5);
    cen_run = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++; if ({busy, up_kf} !== 2'b11) begin errors++; $display("FAIL freeze: got %b required 11", {busy, up_kf}); end
    cen_run = 1'b1;
    wait_ticks(acc + 31);
    checks++; if ({busy, ups} !== {1'b1, 11'd1 << S_KF}) begin errors++; $display("FAIL freeze_t31: got %h required %h", {busy, ups}, {1'b1, 11'd1 << S_KF}); end
    wait_ticks(acc + 32);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL freeze_t32: busy got %b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    reg_wr(8'h10, 8'h55);
    wait_idle();
    reg_wr(8'h21, 8'h99);
    wait_ticks(acc + 22);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, ups, value_A} !== 22'd0) begin errors++; $display("FAIL mid_rst: got %h required 000000", {busy, ups, value_A}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    reg_wr(8'h21, 8'h99);
    checks++; if ({busy, ups, ch, dout} !== {1'b1, 11'd1 << S_RL, 3'd1, 8'h99}) begin errors++; $display("FAIL post_rst: got %h required %h", {busy, ups, ch, dout}, {1'b1, 11'd1 << S_RL, 3'd1, 8'h99}); end
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_kc();
    test_tl();
    test_back_to_back();
    test_keyon();
    test_timers();
    test_cen_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
